// File: rtl/fetch_prefetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_prefetch_unit_if
//  Purpose  : IMEM request/response, redirect and decode-side bundle for the
//             fetch prefetch unit.
//  Revision : 1.0  initial release
// ============================================================================
interface fetch_prefetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        STALL;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        inst_valid;

    // Fetch unit side
    modport master (
        output imem_req_valid, imem_req_addr, pc_out, inst_out, inst_valid,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect, redirect_pc, STALL
    );

    // Memory / pipeline side
    modport slave (
        input  imem_req_valid, imem_req_addr, pc_out, inst_out, inst_valid,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect, redirect_pc, STALL
    );
endinterface
`default_nettype wire

// File: rtl/fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_prefetch_unit
//  Purpose  : Sequential instruction fetch with an in-order prefetch queue,
//             redirect flush and stale-response dropping.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_prefetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_OUT  = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    fetch_prefetch_unit_if.master bus
);
    localparam int unsigned c_qw = $clog2(DEPTH);
    localparam int unsigned c_tw = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned c_ow = $clog2(MAX_OUT + 1);

    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_q_pc   [DEPTH];
    logic [31:0]     r_q_inst [DEPTH];
    logic [c_qw-1:0] r_q_rd;
    logic [c_qw-1:0] r_q_wr;
    logic [c_qw:0]   r_q_cnt;
    logic [31:0]     r_tag    [MAX_OUT];
    logic [c_tw-1:0] r_tag_rd;
    logic [c_tw-1:0] r_tag_wr;
    logic [c_ow-1:0] r_out;
    logic [c_ow-1:0] r_drop;

    logic w_req_valid;
    logic w_issue;
    logic w_rsp;
    logic w_drop;
    logic w_push;
    logic w_pop;
    logic w_empty;

    function automatic logic [c_tw-1:0] tag_inc(input logic [c_tw-1:0] p);
        return (32'(p) == MAX_OUT - 1) ? '0 : p + 1'b1;
    endfunction

    // Room is reserved for every in-flight request so a response can always be pushed.
    assign w_req_valid = rst && !bus.redirect
                       && (32'(r_out) < MAX_OUT)
                       && ((32'(r_q_cnt) + 32'(r_out)) < DEPTH);
    assign w_issue     = w_req_valid && bus.imem_req_ready;
    assign w_rsp       = bus.imem_rsp_valid;
    assign w_drop      = w_rsp && (r_drop != '0);
    assign w_push      = rst && w_rsp && (r_drop == '0) && !bus.redirect;
    assign w_empty     = (r_q_cnt == '0);
    assign w_pop       = !w_empty && !bus.STALL && !bus.redirect;

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_fetch_pc;
    assign bus.inst_valid     = !w_empty;
    assign bus.pc_out         = w_empty ? 32'h0 : r_q_pc[r_q_rd];
    assign bus.inst_out       = w_empty ? 32'h0 : r_q_inst[r_q_rd];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fetch_pc <= RESET_PC;
            r_q_rd     <= '0;
            r_q_wr     <= '0;
            r_q_cnt    <= '0;
            r_tag_rd   <= '0;
            r_tag_wr   <= '0;
            r_out      <= '0;
            r_drop     <= '0;
        end else begin
            case ({w_issue, w_rsp})
                2'b10:   r_out <= r_out + 1'b1;
                2'b01:   r_out <= r_out - 1'b1;
                default: ;
            endcase

            if (bus.redirect) begin
                // Everything still in flight belongs to the old path, except a
                // response landing this very cycle, which is discarded here.
                r_fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
                r_q_rd     <= '0;
                r_q_wr     <= '0;
                r_q_cnt    <= '0;
                r_tag_rd   <= '0;
                r_tag_wr   <= '0;
                r_drop     <= w_rsp ? r_out - 1'b1 : r_out;
            end else begin
                if (w_issue) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                    r_tag_wr   <= tag_inc(r_tag_wr);
                end
                if (w_drop) begin
                    r_drop <= r_drop - 1'b1;
                end
                if (w_push) begin
                    r_q_wr   <= r_q_wr + 1'b1;
                    r_tag_rd <= tag_inc(r_tag_rd);
                end
                if (w_pop) begin
                    r_q_rd <= r_q_rd + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_q_cnt <= r_q_cnt + 1'b1;
                    2'b01:   r_q_cnt <= r_q_cnt - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_tag[r_tag_wr] <= r_fetch_pc;
        end
        if (w_push) begin
            r_q_pc[r_q_wr]   <= r_tag[r_tag_rd];
            r_q_inst[r_q_wr] <= bus.imem_rsp_data;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_prefetch_unit
//  Purpose  : Self-checking bench for fetch_prefetch_unit with an in-order
//             memory model and a queue-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_prefetch_unit;
    localparam logic [31:0] c_reset_pc = 32'h8000_0000;
    localparam int          c_depth    = 4;
    localparam int          c_max_out  = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic        stall;
        logic        exp_iv;
        logic [31:0] exp_pc;
        logic        exp_rv;
        logic [31:0] exp_addr;
    } vec_t;

    logic clk;
    logic rst;
    fetch_prefetch_unit_if bus ();

    fetch_prefetch_unit #(
        .RESET_PC (c_reset_pc),
        .DEPTH    (c_depth),
        .MAX_OUT  (c_max_out)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_checks  = 0;
    int    n_err     = 0;
    int    cyc       = 0;
    int    lat       = 1;
    logic  rdy_rand  = 1'b0;
    logic  model_chk = 1'b0;
    pend_t pend[$];

    // Reference model state: architectural view of the fetch front end
    ent_t        mq[$];
    logic [31:0] m_pc   = c_reset_pc;
    int          m_out  = 0;
    int          m_drop = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic model_rv(input logic r, input logic redir);
        return r && !redir && (m_out < c_max_out) && ((mq.size() + m_out) < c_depth);
    endfunction

    task automatic model_step(input logic r, input logic redir, input logic [31:0] rpc,
                              input logic st, input logic rdy, input logic rsp,
                              input logic [31:0] ra, input logic [31:0] rd);
        logic rv;
        if (!r) begin
            mq.delete();
            m_pc   = c_reset_pc;
            m_out  = 0;
            m_drop = 0;
            return;
        end
        if (rsp) begin
            n_checks++;
            if (m_out == 0) begin
                n_err++;
                $display("FAIL rsp_no_out: response with 0 outstanding (cycle %0d)", cyc);
            end
        end
        if (redir) begin
            mq.delete();
            m_pc = rpc & ~32'h3;
            if (rsp) m_out--;
            m_drop = m_out;
            return;
        end
        rv = model_rv(r, redir);
        if (mq.size() > 0 && !st) void'(mq.pop_front());
        if (rv && rdy) begin
            m_out++;
            m_pc += 32'd4;
        end
        if (rsp) begin
            m_out--;
            if (m_drop > 0) m_drop--;
            else mq.push_back('{ra, rd});
        end
    endtask

    task automatic check_model();
        logic iv;
        iv = (mq.size() > 0);
        chk_b("m_iv", bus.inst_valid, iv);
        if (iv) begin
            chk("m_pc", bus.pc_out, mq[0].pc);
            chk("m_inst", bus.inst_out, mq[0].inst);
        end else begin
            chk("m_pc_empty", bus.pc_out, 32'h0);
            chk("m_inst_empty", bus.inst_out, 32'h0);
        end
        chk_b("m_rv", bus.imem_req_valid, model_rv(rst, bus.redirect));
        if (bus.imem_req_valid) chk("m_addr", bus.imem_req_addr, m_pc);
    endtask

    task automatic settle();
        #1;
        if (model_chk) check_model();
    endtask

    // One clock: update memory and model with this cycle's inputs, cross the edge,
    // then drive the memory outputs for the next cycle.
    task automatic tick();
        logic        hs;
        logic        rsp;
        logic [31:0] ra;
        logic [31:0] rd;
        int          l;
        hs  = bus.imem_req_valid && bus.imem_req_ready;
        rsp = bus.imem_rsp_valid;
        rd  = bus.imem_rsp_data;
        ra  = (pend.size() > 0) ? pend[0].addr : 32'h0;
        model_step(rst, bus.redirect, bus.redirect_pc, bus.STALL, bus.imem_req_ready, rsp, ra, rd);
        if (rsp && pend.size() > 0) void'(pend.pop_front());
        if (!rst) begin
            pend.delete();
        end else if (hs) begin
            l = rdy_rand ? int'($urandom_range(1, 3)) : lat;
            pend.push_back('{bus.imem_req_addr, cyc + l});
        end
        @(posedge clk);
        #1;
        cyc++;
        bus.imem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rst && pend.size() > 0 && pend[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(pend[0].addr);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'hDEAD_BEEF;
        end
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        bus.redirect = 1'b0;
        bus.STALL    = 1'b0;
        settle();
        tick();
        tick();
        model_chk = 1'b1;
        rst       = 1'b1;
    endtask

    task automatic wait_valid(output logic ok);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            settle();
            if (bus.inst_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[16];
        logic        ok;
        int          n_pop;
        logic [31:0] prev;

        rst                = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.redirect       = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.STALL          = 1'b0;

        // Startup with 1-cycle memory, then STALL for 6 cycles and release
        tbl[0]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0000};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0004};
        tbl[2]  = '{1'b0, 1'b1, 32'h8000_0000, 1'b1, 32'h8000_0008};
        tbl[3]  = '{1'b1, 1'b1, 32'h8000_0004, 1'b1, 32'h8000_000C};
        tbl[4]  = '{1'b1, 1'b1, 32'h8000_0004, 1'b1, 32'h8000_0010};
        tbl[5]  = '{1'b1, 1'b1, 32'h8000_0004, 1'b0, 32'h0};
        tbl[6]  = '{1'b1, 1'b1, 32'h8000_0004, 1'b0, 32'h0};
        tbl[7]  = '{1'b1, 1'b1, 32'h8000_0004, 1'b0, 32'h0};
        tbl[8]  = '{1'b1, 1'b1, 32'h8000_0004, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, 1'b1, 32'h8000_0004, 1'b0, 32'h0};
        tbl[10] = '{1'b0, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_0014};
        tbl[11] = '{1'b0, 1'b1, 32'h8000_000C, 1'b1, 32'h8000_0018};
        tbl[12] = '{1'b0, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_001C};
        tbl[13] = '{1'b0, 1'b1, 32'h8000_0014, 1'b1, 32'h8000_0020};
        tbl[14] = '{1'b0, 1'b1, 32'h8000_0018, 1'b1, 32'h8000_0024};
        tbl[15] = '{1'b0, 1'b1, 32'h8000_001C, 1'b1, 32'h8000_0028};

        do_reset();
        for (int i = 0; i < 16; i++) begin
            bus.STALL = tbl[i].stall;
            settle();
            chk_b($sformatf("t%0d_iv", i), bus.inst_valid, tbl[i].exp_iv);
            chk($sformatf("t%0d_pc", i), bus.pc_out, tbl[i].exp_pc);
            chk($sformatf("t%0d_inst", i), bus.inst_out,
                tbl[i].exp_iv ? mem_word(tbl[i].exp_pc) : 32'h0);
            chk_b($sformatf("t%0d_rv", i), bus.imem_req_valid, tbl[i].exp_rv);
            if (tbl[i].exp_rv) chk($sformatf("t%0d_addr", i), bus.imem_req_addr, tbl[i].exp_addr);
            tick();
        end

        // Redirect to an unaligned target with two requests in flight
        do_reset();
        lat       = 1;
        bus.STALL = 1'b1;
        settle(); tick();
        settle(); tick();
        lat = 3;
        ok  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            settle();
            if (pend.size() == 2 && !bus.imem_rsp_valid && bus.inst_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk_b("a_setup", ok, 1'b1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h8000_0103;
        settle();
        chk_b("a_rv_during_redirect", bus.imem_req_valid, 1'b0);
        tick();
        bus.redirect = 1'b0;
        bus.STALL    = 1'b0;
        lat          = 1;
        settle();
        chk_b("a_flush", bus.inst_valid, 1'b0);
        wait_valid(ok);
        chk_b("a_wait", ok, 1'b1);
        chk("a_pc", bus.pc_out, 32'h8000_0100);
        chk("a_inst", bus.inst_out, mem_word(32'h8000_0100));

        // Redirect on a response cycle, then a second redirect the next cycle
        lat = 2;
        ok  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            settle();
            if (bus.imem_rsp_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk_b("b_setup", ok, 1'b1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h8000_0150;
        settle();
        tick();
        bus.redirect_pc = 32'h8000_0200;
        settle();
        tick();
        bus.redirect = 1'b0;
        for (int j = 0; j < 4; j++) begin
            wait_valid(ok);
            chk_b("b_wait", ok, 1'b1);
            chk("b_pc", bus.pc_out, 32'h8000_0200 + 32'(4 * j));
            tick();
        end

        // Random ready, 1..3 cycle latency and random STALL over 200 instructions
        do_reset();
        rdy_rand = 1'b1;
        n_pop    = 0;
        prev     = 32'h0;
        for (int k = 0; k < 3000 && n_pop < 200; k++) begin
            bus.STALL = ($urandom_range(0, 3) == 0);
            settle();
            chk_b("c_out_le_max", pend.size() <= c_max_out, 1'b1);
            if (bus.inst_valid && !bus.STALL) begin
                if (n_pop > 0) chk("c_pc_seq", bus.pc_out, prev + 32'd4);
                prev = bus.pc_out;
                n_pop++;
            end
            tick();
        end
        chk("c_count", n_pop, 200);
        rdy_rand = 1'b0;
        lat      = 1;

        // Reset asserted with a full queue
        bus.STALL = 1'b1;
        ok        = 1'b0;
        for (int k = 0; k < 30; k++) begin
            settle();
            if (mq.size() == c_depth) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk_b("d_full", ok, 1'b1);
        chk_b("d_full_iv", bus.inst_valid, 1'b1);
        rst = 1'b0;
        settle();
        tick();
        settle();
        chk_b("d_rst_iv", bus.inst_valid, 1'b0);
        chk("d_rst_inst", bus.inst_out, 32'h0);
        chk("d_rst_pc", bus.pc_out, 32'h0);
        chk_b("d_rst_rv", bus.imem_req_valid, 1'b0);
        rst       = 1'b1;
        bus.STALL = 1'b0;
        settle();
        chk_b("d_rel_rv", bus.imem_req_valid, 1'b1);
        chk("d_rel_addr", bus.imem_req_addr, c_reset_pc);
        tick();
        wait_valid(ok);
        chk_b("d_wait", ok, 1'b1);
        chk("d_pc", bus.pc_out, c_reset_pc);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Instruction fetch front end with a small in-order prefetch queue.
- Sits directly upstream of the IF/ID pipeline register and replaces the bare PC register, +4 adder and synchronous IMEM read path.
- Issues sequential fetches over a valid/ready request channel and buffers in-order responses, so the decode stage sees a steady instruction stream across stalls and variable memory latency.
- Accepts redirects (taken branch/jump target from execute) and discards every response belonging to the old path.

Parameters:
- RESET_PC, 32'h8000_0000, first fetch address after reset.
- DEPTH, 4, prefetch queue entries (power of two, 2..16).
- MAX_OUT, 2, maximum outstanding IMEM requests (1..DEPTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low (rst==0 resets on the next clk edge).
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_rsp_valid  in  1  response data valid; responses return in request order, at least 1 cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- redirect  in  1  one-cycle pulse: discard the current path and fetch from redirect_pc.
- redirect_pc  in  32  new fetch address; bits [1:0] are ignored and forced to 0.
- STALL  in  1  decode not accepting; the queue head is held.
- pc_out  out  32  PC of the queue head.
- inst_out  out  32  instruction at the queue head.
- inst_valid  out  1  queue head valid.

Behaviour:
- Reset (rst==0 at an edge):
  - fetch_pc=RESET_PC; queue empty; outstanding=0; drop_cnt=0.
  - Outputs: inst_valid=0, inst_out=32'h0, pc_out=32'h0, imem_req_valid=0.
  - Reset overrides every other input, including mid-transaction. Responses arriving after reset to pre-reset requests are the memory's responsibility; the memory is reset on the same edge.
- Request issue: imem_req_valid=1 when rst==1, redirect==0, outstanding<MAX_OUT and occupancy+outstanding<DEPTH.
  - imem_req_addr=fetch_pc.
  - On handshake (valid && ready): fetch_pc+=4 (wraps modulo 2^32), outstanding+=1.
  - imem_req_valid may deassert without a handshake; the address is stable while valid is held.
- Response handling: on imem_rsp_valid, outstanding-=1.
  - If drop_cnt>0: decrement drop_cnt and discard the data.
  - Otherwise push {pc, data}. pc comes from a parallel PC tag FIFO of depth MAX_OUT written on request handshake.
  - An overflowing push cannot occur by construction. The bench asserts imem_rsp_valid never arrives with outstanding==0.
- Output:
  - inst_valid = queue not empty; pc_out/inst_out = head entry, combinational from storage.
  - When the queue is empty, inst_out=0 (the pipeline's bubble encoding) and pc_out=0.
  - Pop when inst_valid && !STALL. With STALL=1 the head is held unchanged indefinitely.
- Same-cycle push and pop on a full queue is legal; occupancy is unchanged.
- Redirect (takes priority over issue, push and pop that cycle):
  - Queue cleared; fetch_pc=redirect_pc & ~3; no request issued this cycle.
  - drop_cnt = outstanding − (imem_rsp_valid ? 1 : 0). The same-cycle response is itself dropped.
  - PC tag FIFO cleared; outstanding reflects the same-cycle response.
  - First new-path request may issue the cycle after redirect. Its response is pushed only once drop_cnt reaches 0.
  - Redirect with STALL=1 still flushes.
  - Back-to-back redirects: the second recomputes drop_cnt from the current outstanding count, and the last target wins.
- Throughput: with ready=1 and 1-cycle response latency, one instruction per cycle after a 2-cycle startup. First inst_valid is 2 cycles after reset release.

Test Plan:
- Reset release, ready=1, 1-cycle memory: req addrs 0x80000000, 0x80000004, 0x80000008…; inst_valid rises on cycle 2 with pc_out=0x80000000; then one instruction per cycle with consecutive PCs.
- STALL held 6 cycles: queue fills to DEPTH=4 with no further requests; head pc/inst unchanged. On STALL release, 4 entries drain in order with no gap or duplicate.
- Redirect to 0x80000103 while 2 requests are outstanding: queue cleared the same edge; 2 stale responses dropped; next pushed entry has pc=0x80000100.
- Redirect coinciding with a response, and a second redirect one cycle later to 0x80000200: only the 0x80000200-path data appears; drop_cnt returns to 0.
- imem_req_ready toggling randomly with 1–3 cycle latency over 200 instructions: PC sequence strictly +4; outstanding never exceeds MAX_OUT=2.
- rst driven low mid-stream with a full queue: next edge gives inst_valid=0, inst_out=0, imem_req_valid=0; after release, fetch restarts at 0x80000000.
